seg7_mux_scan: RTL
==================

// Module: seg7_mux_scan
// PURPOSE
//  Downstream display stage: takes four 4-bit hex digits from the counter/digit logic and drives a
//  4-digit multiplexed 7-segment display. Digit values are double-buffered so frames never tear.
//  Every digit-to-digit switch has a one-cycle all-off gap to stop ghosting.
//  Optional leading-zero blanking. Decodes hex 0-F in-block; no external decoder is needed.
// PARAMETERS
//  REFRESH_COUNT  24'd10_000  clocks per digit slot (1 kHz slot rate at 10 MHz clk); must be >= 2
//  ACTIVE_LOW     1'b0        1: segments and dp are active-low (inverted); digit_en is always active-high
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  value_in     in   16  digits; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3
//  dp_in        in   4   decimal points; dp_in[i] belongs to digit i
//  load         in   1   1-cycle strobe; captures value_in/dp_in into the shadow register
//  blank_lz     in   1   1: enable leading-zero blanking
//  load_ack     out  1   pulses 1 cycle, the cycle after load
//  frame_start  out  1   pulses 1 cycle when the shadow register is copied to the display register
//  segments     out  7   {g,f,e,d,c,b,a}, registered
//  dp           out  1   decimal point for the active digit, registered
//  digit_en     out  4   one-hot digit select, registered
// BEHAVIOUR
//  Reset state: scan_cnt=0, idx=0, shadow=0, disp=0.
//   Outputs at reset: digit_en=0, load_ack=0, frame_start=0; segments and dp at their off level
//   (7'h00/0 when ACTIVE_LOW=0; 7'h7F/1 when ACTIVE_LOW=1).
//  Reset applied mid-frame behaves identically and discards any pending shadow value.
//  scan_cnt counts 0..REFRESH_COUNT-1 and wraps. Tick = (scan_cnt == REFRESH_COUNT-1).
//  On a tick:
//   - idx <= idx+1 (2-bit, 3 wraps to 0).
//   - digit_en <= 0 and segments/dp <= off level (the one-cycle anti-ghost gap).
//  On a non-tick cycle:
//   - digit_en <= onehot(idx).
//   - segments <= enc(disp digit idx).
//   - dp <= disp_dp[idx].
//  Latency and timing:
//   - Each digit is lit REFRESH_COUNT-1 cycles; frame period = 4*REFRESH_COUNT cycles.
//   - First lit cycle: the cycle after reset deasserts, with digit_en=4'b0001.
//  Frame swap (tick while idx==3):
//   - disp <= shadow and disp_dp <= shadow_dp.
//   - frame_start <= 1 for exactly one cycle.
//   - The new value appears from the next lit digit 0.
//  load: shadow <= {value_in, dp_in}; load_ack <= 1 on the next cycle.
//   - Multiple loads within one frame: the last one wins.
//   - A load in the same cycle as a swap: disp takes the OLD shadow; the new value shows one frame later.
//  Leading-zero blanking (blank_lz=1):
//   - Digit i in {3,2,1} is blanked when it and all higher digits of disp are 0.
//   - A blanked digit has segments at the off level; digit_en and dp still follow normal scan.
//   - Digit 0 is never blanked. blank_lz is sampled live, not buffered.
//  enc, active-high form (ACTIVE_LOW=1 inverts segments and dp):
//   0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
// TESTING  (bench uses REFRESH_COUNT=4, ACTIVE_LOW=0 unless stated)
//  1. Hold reset 3 cycles, release.
//     -> Outputs all 0 during reset.
//     -> Next cycle: digit_en=0001, segments=7'h3F.
//     -> Gap (digit_en=0) every 4th cycle; scan order 0001,0010,0100,1000.
//  2. load 16'h1234 at digit 1 of a frame.
//     -> load_ack 1 cycle later; display stays 0 until frame_start.
//     -> Then digits 0..3 show 66,4F,5B,06.
//  3. blank_lz=1, load 16'h0050.
//     -> Digits 3,2 segments=00; digit1=6D; digit0=3F.
//     -> With value 16'h0000, only digit 0 shows 3F.
//  4. Assert load 16'hABCD on the swap cycle.
//     -> That frame still shows the old value; the next frame shows 5E,39,7C,77.
//  5. Assert reset for 1 cycle mid-digit-2 with a pending load.
//     -> All outputs off next cycle; restart at digit 0 showing 3F; the pending value is lost.
//  6. ACTIVE_LOW=1, load 16'h000F with dp_in=4'b0001.
//     -> Digit 0: segments=7'h0E, dp=0. Gap cycles: segments=7'h7F, dp=1.

Source files
------------

// File: rtl/seg7_mux_scan.sv
// Four-digit multiplexed 7-segment driver with a double-buffered digit frame,
// a one-cycle blanking gap between digit slots, and optional leading-zero blanking.
module seg7_mux_scan #(
  parameter logic [23:0] REFRESH_COUNT = 24'd10_000,
  parameter logic        ACTIVE_LOW    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic        load_ack,
  output logic        frame_start,
  output logic [6:0]  segments,
  output logic        dp,
  output logic [3:0]  digit_en
);

  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = ACTIVE_LOW;

  logic [23:0] scan_cnt;
  logic [1:0]  idx;
  logic [15:0] shadow;
  logic [3:0]  shadow_dp;
  logic [15:0] disp;
  logic [3:0]  disp_dp;

  logic        tick;
  logic [3:0]  digit_p0;
  logic [3:0]  lz_p0;
  logic        blank_p0;
  logic [6:0]  seg_on_p0;
  logic [6:0]  seg_lvl_p0;
  logic        dp_lvl_p0;

  function automatic logic [6:0] enc(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] seg_level(input logic [6:0] s);
    return ACTIVE_LOW ? ~s : s;
  endfunction

  assign tick = (scan_cnt == REFRESH_COUNT - 24'd1);

  // Stage p0: select the current digit and resolve blanking from the display buffer
  always_comb begin
    digit_p0   = disp[{idx, 2'b00} +: 4];
    // lz_p0[i]: digit i and every digit above it are zero; digit 0 is never blanked
    lz_p0[3]   = (disp[15:12] == 4'h0);
    lz_p0[2]   = lz_p0[3] && (disp[11:8] == 4'h0);
    lz_p0[1]   = lz_p0[2] && (disp[7:4] == 4'h0);
    lz_p0[0]   = 1'b0;
    blank_p0   = blank_lz && lz_p0[idx];
    seg_on_p0  = blank_p0 ? 7'h00 : enc(digit_p0);
    seg_lvl_p0 = seg_level(seg_on_p0);
    dp_lvl_p0  = ACTIVE_LOW ? ~disp_dp[idx] : disp_dp[idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= 24'd0;
      idx      <= 2'd0;
    end else begin
      scan_cnt <= tick ? 24'd0 : scan_cnt + 24'd1;
      if (tick) idx <= idx + 2'd1;
    end
  end

  // Shadow/display buffers; a load coinciding with a swap lands in the following frame
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow    <= 16'h0000;
      shadow_dp <= 4'h0;
      disp      <= 16'h0000;
      disp_dp   <= 4'h0;
    end else begin
      if (load) begin
        shadow    <= value_in;
        shadow_dp <= dp_in;
      end
      if (tick && idx == 2'd3) begin
        disp    <= shadow;
        disp_dp <= shadow_dp;
      end
    end
  end

  // Stage p1: registered display outputs, forced off on the slot-boundary gap
  always_ff @(posedge clk) begin
    if (reset) begin
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
      digit_en    <= 4'h0;
      segments    <= SEG_OFF;
      dp          <= DP_OFF;
    end else begin
      load_ack    <= load;
      frame_start <= tick && (idx == 2'd3);
      if (tick) begin
        digit_en <= 4'h0;
        segments <= SEG_OFF;
        dp       <= DP_OFF;
      end else begin
        digit_en <= 4'b0001 << idx;
        segments <= seg_lvl_p0;
        dp       <= dp_lvl_p0;
      end
    end
  end

endmodule
